// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sequence_generator_if.sv
// Request/serial-output bundle between a pattern source and the sequence generator.
interface sequence_generator_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    localparam int unsigned LEN_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeats;
    logic             hold;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, repeats, hold,
        input  sout, sout_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, repeats, hold,
        output sout, sout_valid, busy, done
    );

endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with enable; load wins over enable, zero_c flags a count of zero.
module seq_bit_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero_c
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serialises a captured pattern MSB-first, repeating it with one idle gap cycle between passes.
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sequence_generator_if.slave  bus
);

    localparam int unsigned LEN_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_load_val;
    logic [CNT_W-1:0] pass;
    logic             idx_zero;
    logic             pass_zero;
    logic             accept;
    logic             idx_load;
    logic             idx_en;
    logic             pass_en;
    logic             sout_nx;
    logic             valid_nx;
    logic             busy_nx;
    logic             done_nx;

    seq_bit_counter #(.W(LEN_W)) u_idx_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (idx_load_val),
        .en       (idx_en),
        .count    (idx),
        .zero_c   (idx_zero)
    );

    seq_bit_counter #(.W(CNT_W)) u_pass_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.repeats),
        .en       (pass_en),
        .count    (pass),
        .zero_c   (pass_zero)
    );

    // Outputs are the registered image of the current state, so they trail the state by one cycle.
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        idx_load     = 1'b0;
        idx_load_val = len_q;
        idx_en       = 1'b0;
        pass_en      = 1'b0;
        sout_nx      = IDLE_LEVEL;
        valid_nx     = 1'b0;
        busy_nx      = 1'b1;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                busy_nx      = 1'b0;
                idx_load_val = bus.len;
                if (bus.start) begin
                    accept   = 1'b1;
                    idx_load = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                sout_nx  = pat_q[idx];
                valid_nx = !bus.hold;
                if (!bus.hold) begin
                    if (!idx_zero) begin
                        idx_en = 1'b1;
                    end else if (pass_zero) begin
                        state_nx = DONE;
                    end else begin
                        pass_en  = 1'b1;
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                idx_load = 1'b1;
                state_nx = SEND;
            end
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            pat_q          <= '0;
            len_q          <= '0;
            bus.sout       <= IDLE_LEVEL;
            bus.sout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.sout       <= sout_nx;
            bus.sout_valid <= valid_nx;
            bus.busy       <= busy_nx;
            bus.done       <= done_nx;
            if (accept) begin
                pat_q <= bus.pattern;
                len_q <= bus.len;
            end
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator; expected outputs are packed as {sout, sout_valid, busy, done}.
module tb_sequence_generator;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sequence_generator_if #(.WIDTH(8), .CNT_W(4)) bus ();

    sequence_generator #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.sout, bus.sout_valid, bus.busy, bus.done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] pat, input logic [2:0] l, input logic [3:0] rep);
        bus.pattern = pat;
        bus.len     = l;
        bus.repeats = rep;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    localparam logic [3:0] IDLE_O = 4'b1000;
    localparam logic [3:0] GAP_O  = 4'b1010;
    localparam logic [3:0] DONE_O = 4'b1011;

    initial begin
        logic [7:0] exp_pat;
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.hold    = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.repeats = '0;
        tick();
        tick();
        chk("reset_outputs", IDLE_O);
        bus.start = 1'b1;
        tick();
        chk("start_during_reset", IDLE_O);
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        chk("idle_after_reset", IDLE_O);

        // Basic 3-bit pass, plus a start during DONE that must be ignored
        start_tx(8'b0000_0010, 3'd2, 4'd0);
        tick(); chk("s1_bit2", 4'b0110);
        tick(); chk("s1_bit1", 4'b1110);
        bus.pattern = 8'hFF; bus.len = 3'd1; bus.start = 1'b1;
        tick(); chk("s1_bit0", 4'b0110);
        tick(); chk("s1_done", DONE_O);
        bus.start = 1'b0;
        tick(); chk("s1_idle", IDLE_O);
        tick(); chk("s1_start_in_done_ignored", IDLE_O);

        // Full-width pattern with two repeats
        exp_pat = 8'b1011_0000;
        start_tx(exp_pat, 3'd7, 4'd2);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                tick(); chk($sformatf("s2_p%0d_b%0d", p, 7 - i), {exp_pat[7 - i], 3'b110});
            end
            if (p < 2) begin
                tick(); chk($sformatf("s2_gap%0d", p), GAP_O);
            end
        end
        tick(); chk("s2_done", DONE_O);
        tick(); chk("s2_idle", IDLE_O);

        // Hold stalls the bit index for two cycles
        start_tx(8'b0000_0010, 3'd2, 4'd0);
        tick(); chk("s3_bit2", 4'b0110);
        bus.hold = 1'b1;
        tick(); chk("s3_hold_a", 4'b1010);
        tick(); chk("s3_hold_b", 4'b1010);
        bus.hold = 1'b0;
        tick(); chk("s3_bit1", 4'b1110);
        tick(); chk("s3_bit0", 4'b0110);
        tick(); chk("s3_done", DONE_O);
        tick(); chk("s3_idle", IDLE_O);

        // Start while busy must not alter the running pass
        start_tx(8'b0000_1001, 3'd3, 4'd0);
        tick(); chk("s4_bit3", 4'b1110);
        bus.pattern = 8'b0000_0110; bus.len = 3'd3; bus.repeats = 4'd3; bus.start = 1'b1;
        tick(); chk("s4_bit2", 4'b0110);
        bus.start = 1'b0;
        tick(); chk("s4_bit1", 4'b0110);
        tick(); chk("s4_bit0", 4'b1110);
        tick(); chk("s4_done", DONE_O);
        tick(); chk("s4_idle_a", IDLE_O);
        tick(); chk("s4_idle_b", IDLE_O);

        // Reset mid-pass aborts without a done pulse
        start_tx(8'b1100_1010, 3'd7, 4'd1);
        tick(); chk("s5_bit7", 4'b1110);
        tick(); chk("s5_bit6", 4'b1110);
        rst = 1'b0;
        tick(); chk("s5_reset", IDLE_O);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); chk($sformatf("s5_no_done_%0d", i), IDLE_O);
        end
        start_tx(8'b0000_0001, 3'd1, 4'd0);
        tick(); chk("s5_new_bit1", 4'b0110);
        tick(); chk("s5_new_bit0", 4'b1110);
        tick(); chk("s5_new_done", DONE_O);

        // Single-bit passes at the maximum repeat count
        tick();
        start_tx(8'b1111_1110, 3'd0, 4'd15);
        for (int p = 0; p < 16; p++) begin
            tick(); chk($sformatf("s6_pass%0d", p), 4'b0110);
            if (p < 15) begin
                tick(); chk($sformatf("s6_gap%0d", p), GAP_O);
            end
        end
        tick(); chk("s6_done", DONE_O);
        tick(); chk("s6_idle", IDLE_O);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the repeat count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: transmission request; sampled only in IDLE.
REQ-006 The block SHALL have port pattern, input, WIDTH bits: pattern to transmit; captured on an accepted start.
REQ-007 The block SHALL have port len, input, $clog2(WIDTH) bits: pattern length minus 1; captured on an accepted start.
REQ-008 The block SHALL have port repeats, input, CNT_W bits: extra repetitions after the first pass; captured on an accepted start.
REQ-009 The block SHALL have port hold, input, 1 bit: stall request; freezes bit advance while high in SEND.
REQ-010 The block SHALL have port sout, output, 1 bit: serial data.
REQ-011 The block SHALL have port sout_valid, output, 1 bit: sout carries a pattern bit this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the final pass completes.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, SEND, GAP, DONE.
REQ-015 In IDLE with start=1, the block SHALL capture pattern, len and repeats, load bit index = len, load pass counter = repeats, and enter SEND next cycle.
REQ-016 Start in any state other than IDLE SHALL be ignored, with no effect on captured values.
REQ-017 In SEND, the block SHALL drive sout = captured pattern[index], MSB-first from pattern[len] down to pattern[0].
REQ-018 In SEND, sout_valid SHALL equal !hold.
REQ-019 In SEND, the index SHALL decrement only on cycles with hold=0.
REQ-020 During hold, sout SHALL keep the current bit value.
REQ-021 When bit 0 is sent (hold=0) and the pass counter is nonzero, the block SHALL decrement the pass counter and go to GAP.
REQ-022 When bit 0 is sent (hold=0) and the pass counter is zero, the block SHALL go to DONE.
REQ-023 GAP SHALL last exactly one cycle, with sout=1 and sout_valid=0, then return to SEND with index = len.
REQ-024 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-025 If start=1 during DONE, it SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-026 In IDLE and DONE, the block SHALL drive sout=1 and sout_valid=0.
REQ-027 Latency with no hold: start sampled at edge t gives bits on cycles t+1 .. t+N, with N = len+1.
REQ-028 With no hold and R = repeats, done SHALL be asserted on cycle t+(R+1)*N+R+1.
REQ-029 len=0 SHALL send a single bit pattern[0] per pass.
REQ-030 repeats at its maximum value SHALL give 2^CNT_W passes, with no wrap of the pass counter.
REQ-031 Pattern bits above len SHALL be ignored.
REQ-032 A len value of WIDTH or greater SHALL never occur in the 8-bit default configuration, since a 3-bit len cannot exceed 7.

Reset
REQ-033 On any rising clk edge with rst=0, the block SHALL enter IDLE regardless of current state, including mid-pass, GAP or DONE.
REQ-034 Reset values SHALL be: sout=1, sout_valid=0, busy=0, done=0, and index, pass counter and captured registers all zero.
REQ-035 A reset during a transmission SHALL produce no done pulse.
REQ-036 Start SHALL be ignored on any cycle with rst=0.

Structure
REQ-037 Package seq_gen_pkg SHALL hold the state typedef (IDLE, SEND, GAP, DONE) and the constant IDLE_LEVEL = 1'b1.
REQ-038 One sub-module, seq_bit_counter, SHALL implement the loadable down-counter with enable and zero flag, instanced twice: once for the bit index and once for the pass counter.
REQ-039 All outputs SHALL be registered.

Verification
REQ-040 Scenario: pattern=8'b0000_0010, len=2, repeats=0, hold=0 -> sout_valid high on cycles 1-3 with sout 0,1,0; done on cycle 4; busy low on cycle 5.
REQ-041 Scenario: pattern=8'b1011_0000, len=7, repeats=2 -> three passes of 1,0,1,1,0,0,0,0; one GAP cycle (sout=1, sout_valid=0) between passes; done on cycle 27.
REQ-042 Scenario: len=2 pattern 010, hold=1 on cycles 2-3 -> sout stays 1 with sout_valid=0 on cycles 2-3; final bit 0 on cycle 5; done on cycle 6.
REQ-043 Scenario: start pulsed on cycle 2 of a busy pass with different pattern -> first transmission unaltered; no second transmission.
REQ-044 Scenario: rst=0 on cycle 2 of a len=7 pass -> next cycle sout=1, sout_valid=0, busy=0; done never asserts; a new start after release transmits normally.
REQ-045 Scenario: len=0, repeats=15, pattern bit0=0 -> sixteen single-bit passes with sout=0, separated by fifteen GAP cycles; done on cycle 32.
